ibex_lsu_resp_unit: RTL

Load/store response side of the LSU; the producer of the LSU write-back interface (rf_wdata_lsu, rf_we_lsu, rf_lsu_to_fp, lsu_resp_valid, lsu_resp_err).
- Records the attributes of each issued data request in a small in-order FIFO.
- Consumes data-bus responses (including misaligned two-beat transactions) and aligns and extends load data.
- Routes the completed result to the integer or FP register-file write path in the response cycle.

---
 rtl/ibex_pkg.sv | 39 +++
 rtl/ibex_lsu_load_align.sv | 61 ++++++
 rtl/ibex_lsu_resp_unit.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/ibex_pkg.sv
// Shared LSU types: access size encodings, response record and FSM states.
// Also holds the load data extension helper.
package ibex_pkg;

  typedef enum logic [1:0] {
    LSU_TYPE_W = 2'b00,
    LSU_TYPE_H = 2'b01,
    LSU_TYPE_B = 2'b10
  } lsu_type_e;

  typedef struct packed {
    logic [1:0] data_type;
    logic       sign_ext;
    logic [1:0] offset;
    logic       we;
    logic       split;
    logic       to_fp;
  } lsu_resp_rec_t;

  typedef enum logic {
    LSU_RESP_IDLE,
    LSU_RESP_SECOND
  } lsu_resp_state_e;

  function automatic logic [31:0] lsu_ext16(
    input logic [15:0] v,
    input logic        sext
  );
    return {{16{sext & v[15]}}, v};
  endfunction

  function automatic logic [31:0] lsu_ext8(
    input logic [7:0] v,
    input logic       sext
  );
    return {{24{sext & v[7]}}, v};
  endfunction

endpackage

// File: rtl/ibex_lsu_load_align.sv
// Load data alignment and extension, including the two-beat merge of a
// misaligned access (current beat supplies the upper bytes).
module ibex_lsu_load_align
  import ibex_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [31:0] rdata_q_i,
  input  logic [1:0]  type_i,
  input  logic [1:0]  offset_i,
  input  logic        sign_ext_i,
  input  logic        second_beat_i,
  output logic [31:0] result_o
);

  logic [5:0]  shamt;
  logic [31:0] word;
  logic [15:0] half;
  logic [7:0]  byte_v;

  assign shamt = {1'b0, offset_i, 3'b000};

  always_comb begin
    word = rdata_i;
    if (second_beat_i) begin
      word = (rdata_q_i >> shamt) | (rdata_i << (6'd32 - shamt));
    end
  end

  always_comb begin
    half = rdata_i[15:0];
    unique case (offset_i)
      2'd0: half = rdata_i[15:0];
      2'd1: half = rdata_i[23:8];
      2'd2: half = rdata_i[31:16];
      2'd3: half = {rdata_i[7:0], rdata_q_i[31:24]};
      default: half = rdata_i[15:0];
    endcase
  end

  always_comb begin
    byte_v = rdata_i[7:0];
    unique case (offset_i)
      2'd0: byte_v = rdata_i[7:0];
      2'd1: byte_v = rdata_i[15:8];
      2'd2: byte_v = rdata_i[23:16];
      2'd3: byte_v = rdata_i[31:24];
      default: byte_v = rdata_i[7:0];
    endcase
  end

  always_comb begin
    result_o = word;
    unique case (1'b1)
      type_i[1]:          result_o = lsu_ext8(byte_v, sign_ext_i);
      (type_i == 2'b01):  result_o = lsu_ext16(half, sign_ext_i);
      (type_i == 2'b00):  result_o = word;
      default:            result_o = word;
    endcase
  end

endmodule

// File: rtl/ibex_lsu_resp_unit.sv
// LSU response side: in-order request-attribute FIFO, two-beat response FSM
// and routing of the completed load to the integer or FP write-back path.
module ibex_lsu_resp_unit
  import ibex_pkg::*;
#(
  parameter int unsigned NumOutstanding = 2,
  parameter bit          ResetAll       = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_type_i,
  input  logic        req_sign_ext_i,
  input  logic [1:0]  req_offset_i,
  input  logic        req_we_i,
  input  logic        req_split_i,
  input  logic        req_to_fp_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i,
  output logic [31:0] rf_wdata_lsu_o,
  output logic        rf_we_lsu_o,
  output logic        rf_we_fp_lsu_o,
  output logic        rf_lsu_to_fp_o,
  output logic        lsu_resp_valid_o,
  output logic        lsu_resp_err_o,
  output logic        busy_o,
  output logic        resp_unexpected_o
);

  localparam int unsigned PtrW =
    (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;
  localparam int unsigned CntW = $clog2(NumOutstanding + 1);
  localparam logic [CntW-1:0] Depth = CntW'(NumOutstanding);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(NumOutstanding - 1);

  lsu_resp_rec_t   mem_q [NumOutstanding];
  lsu_resp_rec_t   rec_in;
  lsu_resp_rec_t   head;
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] cnt_q;
  logic [31:0]     rdata_q;
  logic            err_q;
  logic            unexp_q;
  logic            push, empty, full, rvalid_ok;
  logic            capture, complete;
  logic            resp_err, load_ok;
  logic [31:0]     aligned;

  lsu_resp_state_e state_q, state_d;

  function automatic logic [PtrW-1:0] bump(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == Depth);
  assign push      = req_valid_i & ~full;
  assign rvalid_ok = data_rvalid_i & ~empty;
  assign head      = mem_q[rptr_q];

  assign rec_in = '{
    data_type: req_type_i,
    sign_ext:  req_sign_ext_i,
    offset:    req_offset_i,
    we:        req_we_i,
    split:     req_split_i,
    to_fp:     req_to_fp_i
  };

  if (ResetAll) begin : g_data_rst
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < int'(NumOutstanding); i++) begin
          mem_q[i] <= '0;
        end
        rdata_q <= '0;
      end else begin
        if (push) mem_q[wptr_q] <= rec_in;
        if (capture) rdata_q <= data_rdata_i;
      end
    end
  end else begin : g_data_nrst
    always_ff @(posedge clk_i) begin
      if (push) mem_q[wptr_q] <= rec_in;
      if (capture) rdata_q <= data_rdata_i;
    end
  end

  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      LSU_RESP_IDLE: begin
        if (rvalid_ok) begin
          if (head.split) begin
            capture = 1'b1;
            state_d = LSU_RESP_SECOND;
          end else begin
            complete = 1'b1;
          end
        end
      end
      LSU_RESP_SECOND: begin
        if (rvalid_ok) begin
          complete = 1'b1;
          state_d  = LSU_RESP_IDLE;
        end
      end
      default: state_d = LSU_RESP_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= LSU_RESP_IDLE;
      err_q   <= 1'b0;
      unexp_q <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        err_q <= err_q | data_err_i;
      end else if (complete) begin
        err_q <= 1'b0;
      end
      if (data_rvalid_i & empty) unexp_q <= 1'b1;
      if (push) wptr_q <= bump(wptr_q);
      if (complete) rptr_q <= bump(rptr_q);
      if (push & ~complete) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (complete & ~push) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  ibex_lsu_load_align u_align (
    .rdata_i       (data_rdata_i),
    .rdata_q_i     (rdata_q),
    .type_i        (head.data_type),
    .offset_i      (head.offset),
    .sign_ext_i    (head.sign_ext),
    .second_beat_i (state_q == LSU_RESP_SECOND),
    .result_o      (aligned)
  );

  // Beat-1 errors sit in err_q until the final beat completes.
  assign resp_err = data_err_i | err_q;
  assign load_ok  = complete & ~head.we & ~resp_err;

  assign req_ready_o       = ~full;
  assign busy_o            = ~empty;
  assign resp_unexpected_o = unexp_q;
  assign lsu_resp_valid_o  = complete;
  assign lsu_resp_err_o    = complete & resp_err;
  assign rf_we_lsu_o       = load_ok & ~head.to_fp;
  assign rf_we_fp_lsu_o    = load_ok & head.to_fp;
  assign rf_lsu_to_fp_o    = complete & head.to_fp;
  assign rf_wdata_lsu_o    = (complete & ~head.we) ? aligned : '0;

  a_no_push_full : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    req_valid_i |-> req_ready_o
  );

  a_fp_word_only : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (req_valid_i & req_ready_o & req_to_fp_i) |->
      (req_type_i == LSU_TYPE_W)
  );

endmodule
